// File: rtl/binario_a_bcd.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble, one shift per clock).
// Optional leap-year flag enabled by defining BINBCD_LEAP_EN; otherwise leap is tied low.
module binario_a_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic        leap
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [29:0] work_q, work_d;
    logic [29:0] work_adj, work_shl;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;
    logic        accept, last_iter;

    assign accept    = (state_q == S_IDLE) && start;
    assign last_iter = (state_q == S_SHIFT) && (cnt_q == 4'd13);

    // Add-3 on every BCD nibble that is 5 or more, then shift the whole register.
    always_comb begin
        work_adj = work_q;
        for (int n = 0; n < 4; n++) begin
            if (work_q[14 + 4*n +: 4] >= 4'd5)
                work_adj[14 + 4*n +: 4] = work_q[14 + 4*n +: 4] + 4'd3;
        end
        work_shl = {work_adj[28:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SHIFT;
                    work_d     = {16'b0, bin};
                    cnt_d      = 4'd0;
                    ovf_pend_d = (bin > 14'd9999);
                end
            end
            S_SHIFT: begin
                work_d = work_shl;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = S_DONE;
                    bcd_d   = ovf_pend_q ? 16'h9999 : work_shl[29:14];
                    ovf_d   = ovf_pend_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            work_q     <= 30'd0;
            cnt_q      <= 4'd0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef BINBCD_LEAP_EN
    // The low binary bits give year % 4 directly; the century test uses (2*thousands + hundreds) % 4.
    logic [1:0] bin_lo_q, bin_lo_d;
    logic       leap_q, leap_d;
    logic [1:0] cent_mod;

    assign cent_mod = {work_shl[26], 1'b0} + work_shl[23:22];

    always_comb begin
        bin_lo_d = bin_lo_q;
        leap_d   = leap_q;
        if (accept)
            bin_lo_d = bin[1:0];
        if (last_iter)
            leap_d = !ovf_pend_q && (bin_lo_q == 2'd0) &&
                     ((work_shl[21:14] != 8'h00) || (cent_mod == 2'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_lo_q <= 2'd0;
            leap_q   <= 1'b0;
        end else begin
            bin_lo_q <= bin_lo_d;
            leap_q   <= leap_d;
        end
    end

    assign leap = leap_q;
`else
    assign leap = 1'b0;
`endif

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule
